// File: rtl/io_fabric_if.sv
// Bus bundle between the CPU, the I/O fabric and its peripheral slots.
// The fabric uses the slave view; the CPU/peripheral environment uses the master view.
interface io_fabric_if #(
  parameter int NSLOT = 4
);
  logic                 cpu_en;
  logic                 cpu_wr;
  logic                 cpu_wide;
  logic [15:0]          cpu_addr;
  logic [15:0]          cpu_dout;
  logic [15:0]          cpu_din;
  logic                 cpu_stall;
  logic                 mem_sel;
  logic [NSLOT-1:0]     s_req;
  logic                 s_wr;
  logic                 s_wide;
  logic [9:0]           s_addr;
  logic [15:0]          s_wdata;
  logic [NSLOT-1:0]     s_ack;
  logic [16*NSLOT-1:0]  s_rdata;

  modport master (
    output cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_dout, s_ack, s_rdata,
    input  cpu_din, cpu_stall, mem_sel, s_req, s_wr, s_wide, s_addr, s_wdata
  );

  modport slave (
    input  cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_dout, s_ack, s_rdata,
    output cpu_din, cpu_stall, mem_sel, s_req, s_wr, s_wide, s_addr, s_wdata
  );
endinterface

// File: rtl/io_fabric.sv
// I/O window decoder and single-outstanding-access bridge from the CPU to NSLOT
// peripheral slots, with a per-access timeout that raises a sticky bus error.
module io_fabric #(
  parameter logic [5:0] IO_PREFIX = 6'h3f,
  parameter int         NSLOT     = 4,
  parameter int         SLOT_BITS = 2,
  parameter int         TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  io_fabric_if.slave  bus,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [15:0] err_addr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [NSLOT-1:0] SLOT0_ONEHOT = {{(NSLOT-1){1'b0}}, 1'b1};

  state_t               state;
  logic [7:0]           wait_cnt;
  logic [SLOT_BITS-1:0] sel;
  logic [SLOT_BITS-1:0] hit_slot;
  logic [NSLOT-1:0]     req;
  logic                 wr_q;
  logic                 wide_q;
  logic [9:0]           addr_q;
  logic [15:0]          wdata_q;
  logic [15:0]          din_q;
  logic                 io_hit;
  logic                 sel_ack;
  logic [15:0]          sel_data;
  logic [15:0]          read_word;

  assign io_hit   = bus.cpu_en & (bus.cpu_addr[15:10] == IO_PREFIX);
  assign hit_slot = bus.cpu_addr[9:10-SLOT_BITS];

  assign bus.mem_sel   = bus.cpu_en & (bus.cpu_addr[15:10] != IO_PREFIX);
  assign bus.cpu_stall = ((state == IDLE) & io_hit) | (state == WAIT);
  assign bus.cpu_din   = din_q;
  assign bus.s_req     = req;
  assign bus.s_wr      = wr_q;
  assign bus.s_wide    = wide_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;

  // Only the slot latched at request time may complete the access.
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = 16'h0000;
    for (int k = 0; k < NSLOT; k++) begin
      if (sel == SLOT_BITS'(k)) begin
        sel_ack  = bus.s_ack[k];
        sel_data = bus.s_rdata[16*k +: 16];
      end
    end
  end

  assign read_word = wide_q ? sel_data : {8'h00, sel_data[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      sel      <= '0;
      req      <= '0;
      wr_q     <= 1'b0;
      wide_q   <= 1'b0;
      addr_q   <= 10'd0;
      wdata_q  <= 16'h0000;
      din_q    <= 16'h0000;
      bus_err  <= 1'b0;
      err_addr <= 16'h0000;
    end else begin
      // A timeout below overrides a clear issued in the same cycle.
      if (err_clr) begin
        bus_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (io_hit) begin
            addr_q   <= bus.cpu_addr[9:0];
            wr_q     <= bus.cpu_wr;
            wide_q   <= bus.cpu_wide;
            wdata_q  <= bus.cpu_dout;
            sel      <= hit_slot;
            req      <= SLOT0_ONEHOT << hit_slot;
            wait_cnt <= 8'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (sel_ack) begin
            req <= '0;
            if (!wr_q) begin
              din_q <= read_word;
            end
            state <= DONE;
          end else if ((wait_cnt + 8'd1) == TIMEOUT_CNT) begin
            req      <= '0;
            bus_err  <= 1'b1;
            err_addr <= {IO_PREFIX, addr_q};
            if (!wr_q) begin
              din_q <= 16'hffff;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_fabric.sv
// Self-checking bench for io_fabric: an access-level model predicts every output
// each cycle from the access description, plus literal checks on key results.
module tb_io_fabric;

  localparam logic [5:0] IO_PREFIX = 6'h3f;
  localparam int         NSLOT     = 4;
  localparam int         SLOT_BITS = 2;
  localparam int         TIMEOUT   = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clr;
  logic        bus_err;
  logic [15:0] err_addr;

  io_fabric_if #(.NSLOT(NSLOT)) bus ();

  io_fabric #(
    .IO_PREFIX(IO_PREFIX),
    .NSLOT    (NSLOT),
    .SLOT_BITS(SLOT_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err_clr (err_clr),
    .bus_err (bus_err),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic        check_en = 1'b0;
  logic        clr_pending = 1'b0;
  logic        exp_stall, exp_mem_sel, exp_s_wr, exp_s_wide, exp_err;
  logic [3:0]  exp_req;
  logic [9:0]  exp_s_addr;
  logic [15:0] exp_s_wdata, exp_din, exp_err_addr;
  logic [15:0] slot_data [NSLOT];
  int          stall_cnt, req_cnt;
  logic [3:0]  req_first;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cpu_stall", 16'(bus.cpu_stall), 16'(exp_stall));
      checkOutput("mem_sel",   16'(bus.mem_sel),   16'(exp_mem_sel));
      checkOutput("s_req",     16'(bus.s_req),     16'(exp_req));
      checkOutput("s_wr",      16'(bus.s_wr),      16'(exp_s_wr));
      checkOutput("s_wide",    16'(bus.s_wide),    16'(exp_s_wide));
      checkOutput("s_addr",    16'(bus.s_addr),    16'(exp_s_addr));
      checkOutput("s_wdata",   bus.s_wdata,        exp_s_wdata);
      checkOutput("cpu_din",   bus.cpu_din,        exp_din);
      checkOutput("bus_err",   16'(bus_err),       16'(exp_err));
      checkOutput("err_addr",  err_addr,           exp_err_addr);
    end
  end

  task automatic clearModel();
    exp_stall = 1'b0; exp_mem_sel = 1'b0; exp_req = 4'b0000;
    exp_s_wr = 1'b0; exp_s_wide = 1'b0; exp_s_addr = 10'd0; exp_s_wdata = 16'h0000;
    exp_din = 16'h0000; exp_err = 1'b0; exp_err_addr = 16'h0000;
    clr_pending = 1'b0;
  endtask

  // An err_clr driven in one cycle is visible as a cleared flag in the next.
  task automatic beginCycle();
    @(posedge clk);
    #1;
    if (clr_pending) exp_err = 1'b0;
    clr_pending = 1'b0;
  endtask

  task automatic idleCycle(input logic clr);
    beginCycle();
    bus.cpu_en = 1'b0;
    bus.s_ack  = '0;
    err_clr    = clr;
    clr_pending = clr;
    exp_stall = 1'b0; exp_mem_sel = 1'b0; exp_req = 4'b0000;
    @(negedge clk);
  endtask

  // ack_at: WAIT cycle (1-based) in which the target slot acks; 0 = never.
  // clr_at: access cycle in which err_clr is pulsed; -1 = never.
  // stray_until: slot 0 acks in WAIT cycles 1..stray_until while another slot is targeted.
  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic wide,
                               input logic [15:0] wdata, input int ack_at,
                               input logic [15:0] rdata, input int clr_at, input int stray_until);
    int         slot;
    int         end_wait;
    logic       timed_out;
    logic [3:0] onehot;
    logic [3:0] ack;
    slot      = int'(addr[9:8]);
    onehot    = 4'b0001 << slot;
    timed_out = !(ack_at >= 1 && ack_at <= TIMEOUT);
    end_wait  = timed_out ? TIMEOUT : ack_at;
    stall_cnt = 0;
    req_cnt   = 0;
    req_first = 4'b0000;
    slot_data[slot] = rdata;
    if (stray_until > 0 && slot != 0) slot_data[0] = 16'h1111;
    bus.s_rdata = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};
    for (int k = 0; k <= end_wait + 1; k++) begin
      beginCycle();
      bus.cpu_en   = 1'b1;
      bus.cpu_wr   = wr;
      bus.cpu_wide = wide;
      bus.cpu_addr = addr;
      bus.cpu_dout = wdata;
      ack = 4'b0000;
      if (ack_at >= 1 && k == ack_at) ack[slot] = 1'b1;
      if (k >= 1 && k <= stray_until && slot != 0) ack[0] = 1'b1;
      bus.s_ack   = ack;
      err_clr     = (k == clr_at);
      clr_pending = err_clr;
      exp_stall   = (k <= end_wait);
      exp_mem_sel = 1'b0;
      exp_req     = (k >= 1 && k <= end_wait) ? onehot : 4'b0000;
      if (k == 1) begin
        exp_s_addr = addr[9:0]; exp_s_wr = wr; exp_s_wide = wide; exp_s_wdata = wdata;
      end
      if (k == end_wait + 1) begin
        if (!wr) exp_din = timed_out ? 16'hffff : (wide ? rdata : {8'h00, rdata[7:0]});
        if (timed_out) begin
          exp_err = 1'b1;
          exp_err_addr = addr;
        end
      end
      @(negedge clk);
      if (bus.cpu_stall) stall_cnt++;
      if (bus.s_req != 4'b0000) req_cnt++;
      if (k == 1) req_first = bus.s_req;
    end
  endtask

  initial begin
    for (int i = 0; i < NSLOT; i++) slot_data[i] = 16'h0000;
    reset = 1'b1;
    err_clr = 1'b0;
    bus.cpu_en = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_wide = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_dout = 16'h0000;
    bus.s_ack = '0; bus.s_rdata = '0;
    clearModel();
    #1 check_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_din", bus.cpu_din, 16'h0000);
    beginCycle();
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(16'hfc42, 1'b0, 1'b1, 16'h0000, 1, 16'h1234, -1, 0);
    checkOutput("zero_wait_stall_cycles", 16'(stall_cnt), 16'd2);
    checkOutput("zero_wait_first_req", 16'(req_first), 16'h0001);
    checkOutput("zero_wait_din", bus.cpu_din, 16'h1234);
    idleCycle(1'b0);

    applyStimulus(16'hfe10, 1'b0, 1'b0, 16'h0000, 4, 16'hABCD, -1, 0);
    checkOutput("byte_read_stall_cycles", 16'(stall_cnt), 16'd5);
    checkOutput("byte_read_din", bus.cpu_din, 16'h00CD);
    idleCycle(1'b0);

    for (int m = 0; m < 2; m++) begin
      beginCycle();
      bus.cpu_en = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_wide = 1'b1;
      bus.cpu_addr = (m == 0) ? 16'h8000 : 16'hfbff;
      bus.cpu_dout = 16'h7777; bus.s_ack = '0; err_clr = 1'b0;
      exp_stall = 1'b0; exp_mem_sel = 1'b1; exp_req = 4'b0000;
      @(negedge clk);
      checkOutput("mem_access_sel", 16'(bus.mem_sel), 16'h0001);
    end
    idleCycle(1'b0);

    applyStimulus(16'hfd00, 1'b0, 1'b1, 16'h0000, 4, 16'h2222, -1, 2);
    checkOutput("stray_ack_din", bus.cpu_din, 16'h2222);
    checkOutput("stray_ack_stall_cycles", 16'(stall_cnt), 16'd5);
    idleCycle(1'b0);

    applyStimulus(16'hff00, 1'b1, 1'b1, 16'h5A5A, 0, 16'h0000, -1, 0);
    checkOutput("timeout_req_cycles", 16'(req_cnt), 16'd15);
    checkOutput("timeout_bus_err", 16'(bus_err), 16'h0001);
    checkOutput("timeout_err_addr", err_addr, 16'hff00);
    checkOutput("timeout_write_din", bus.cpu_din, 16'h2222);
    idleCycle(1'b0);

    applyStimulus(16'hfe20, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, TIMEOUT, 0);
    checkOutput("clr_vs_timeout_err", 16'(bus_err), 16'h0001);
    checkOutput("timeout_read_din", bus.cpu_din, 16'hffff);
    idleCycle(1'b0);

    for (int k = 0; k < 3; k++) begin
      beginCycle();
      bus.cpu_en = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_wide = 1'b1;
      bus.cpu_addr = 16'hfd00; bus.s_ack = '0; err_clr = 1'b0;
      exp_stall = 1'b1; exp_mem_sel = 1'b0;
      exp_req = (k == 0) ? 4'b0000 : 4'b0010;
      if (k == 1) begin
        exp_s_addr = 10'h100; exp_s_wr = 1'b0; exp_s_wide = 1'b1; exp_s_wdata = bus.cpu_dout;
      end
      if (k == 2) begin
        #2;
        reset = 1'b1;
        bus.cpu_en = 1'b0;
        clearModel();
        #1;
        checkOutput("reset_async_req", 16'(bus.s_req), 16'h0000);
        checkOutput("reset_async_stall", 16'(bus.cpu_stall), 16'h0000);
        checkOutput("reset_async_err", 16'(bus_err), 16'h0000);
      end
      @(negedge clk);
    end
    beginCycle();
    reset = 1'b0;
    @(negedge clk);
    beginCycle();
    bus.s_ack = 4'b0010;
    @(negedge clk);
    idleCycle(1'b0);

    applyStimulus(16'hff04, 1'b0, 1'b1, 16'h0000, TIMEOUT, 16'h4321, -1, 0);
    checkOutput("ack_at_limit_err", 16'(bus_err), 16'h0000);
    checkOutput("ack_at_limit_din", bus.cpu_din, 16'h4321);
    idleCycle(1'b0);

    applyStimulus(16'hfe30, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, -1, 0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("err_clr_idle", 16'(bus_err), 16'h0000);

    applyStimulus(16'hfc10, 1'b1, 1'b1, 16'hBEEF, 2, 16'h0000, -1, 0);
    checkOutput("write_ack_din", bus.cpu_din, 16'hffff);
    idleCycle(1'b0);
    applyStimulus(16'hfd81, 1'b0, 1'b0, 16'h0000, 1, 16'h9876, -1, 0);
    checkOutput("byte_zero_wait_din", bus.cpu_din, 16'h0076);
    idleCycle(1'b0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
